// File: rtl/f_div.sv
// Iterative IEEE-754 single-precision divider: restoring division, one quotient bit
// per cycle, round-to-nearest-even, flush-to-zero, constant latency for all operands.
module f_div #(
  parameter int DATA_W  = 32,
  parameter int EXP_W   = 8,
  parameter int LATENCY = 29
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              running,
  input  logic              run,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  output logic [DATA_W-1:0] out0,
  output logic              done
);

  localparam int MAN_W = DATA_W - EXP_W - 1;
  localparam int Q_W   = MAN_W + 3;
  // One UNPACK and one ROUND cycle bracket the DIV state; DIV spends one cycle past
  // the last iteration latching the sticky bit.
  localparam logic [4:0] DIV_LAST = 5'(LATENCY - 3);
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [DATA_W-1:0] QNAN = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, UNPACK, DIV, ROUND} state_t;

  state_t              state_q;
  logic [4:0]          cnt_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic                sign_q;
  logic signed [9:0]   ediff_q;
  logic [MAN_W:0]      mb_q;
  logic [Q_W-1:0]      rem_q, quo_q;
  logic                sticky_q;
  logic                spec_q;
  logic [DATA_W-1:0]   spec_val_q;
  logic [DATA_W-1:0]   out0_q;
  logic                done_q;

  assign out0 = out0_q;
  assign done = done_q;

  // Operand unpacking and special-case classification
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             za, zb, ia, ib, na, nb, sign_d;
  logic             spec_d;
  logic [DATA_W-1:0] spec_val_d;

  always_comb begin
    ea     = a_q[DATA_W-2 -: EXP_W];
    eb     = b_q[DATA_W-2 -: EXP_W];
    fa     = a_q[MAN_W-1:0];
    fb     = b_q[MAN_W-1:0];
    sign_d = a_q[DATA_W-1] ^ b_q[DATA_W-1];
    za     = (ea == '0);
    zb     = (eb == '0);
    ia     = (ea == EXP_MAX) && (fa == '0);
    ib     = (eb == EXP_MAX) && (fb == '0);
    na     = (ea == EXP_MAX) && (fa != '0);
    nb     = (eb == EXP_MAX) && (fb != '0);
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    spec_d     = 1'b1;
    spec_val_d = '0;
    if (na || nb || (za && zb) || (ia && ib))
      spec_val_d = QNAN;
    else if (ia || zb)
      spec_val_d = {sign_d, EXP_MAX, {MAN_W{1'b0}}};
    else if (za || ib)
      spec_val_d = {sign_d, {(DATA_W-1){1'b0}}};
    else
      spec_d = 1'b0;
  end

  // One restoring-division step
  logic           q_bit;
  logic [Q_W-1:0] rem_d, quo_d;

  always_comb begin
    q_bit = (rem_q >= Q_W'(mb_q));
    rem_d = Q_W'((q_bit ? rem_q - Q_W'(mb_q) : rem_q) << 1);
    quo_d = {quo_q[Q_W-2:0], q_bit};
  end

  // Normalise, round to nearest even, range check
  logic [MAN_W-1:0]  mant;
  logic [MAN_W:0]    mant_r;
  logic              guard, sticky, round_up;
  logic signed [9:0] exp_n, exp_r;
  logic [DATA_W-1:0] res_d;

  always_comb begin
    if (quo_q[Q_W-1]) begin
      mant   = quo_q[Q_W-2:2];
      guard  = quo_q[1];
      sticky = sticky_q | quo_q[0];
      exp_n  = ediff_q + 10'sd127;
    end else begin
      mant   = quo_q[Q_W-3:1];
      guard  = quo_q[0];
      sticky = sticky_q;
      exp_n  = ediff_q + 10'sd126;
    end
    round_up = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + (MAN_W+1)'(round_up);
    exp_r    = exp_n + $signed({9'd0, mant_r[MAN_W]});
    if (spec_q)
      res_d = spec_val_q;
    else if (exp_r >= 10'sd255)
      res_d = {sign_q, EXP_MAX, {MAN_W{1'b0}}};
    else if (exp_r <= 10'sd0)
      res_d = {sign_q, {(DATA_W-1){1'b0}}};
    else
      res_d = {sign_q, exp_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: datapath registers are not reset; each is reloaded before it is read.
      state_q <= IDLE;
      cnt_q   <= '0;
      out0_q  <= '0;
      done_q  <= 1'b0;
    end else if (running) begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (run) begin
            a_q     <= in0;
            b_q     <= in1;
            state_q <= UNPACK;
          end
        end
        UNPACK: begin
          sign_q     <= sign_d;
          ediff_q    <= $signed({2'b00, ea}) - $signed({2'b00, eb});
          mb_q       <= {~zb, fb};
          rem_q      <= Q_W'({~za, fa});
          quo_q      <= '0;
          cnt_q      <= '0;
          spec_q     <= spec_d;
          spec_val_q <= spec_val_d;
          state_q    <= DIV;
        end
        DIV: begin
          if (cnt_q == DIV_LAST) begin
            sticky_q <= (rem_q != '0);
            state_q  <= ROUND;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 5'd1;
          end
        end
        ROUND: begin
          out0_q <= res_d;
          done_q <= 1'b1;
          cnt_q  <= '0;
          if (run) begin
            a_q     <= in0;
            b_q     <= in1;
            state_q <= UNPACK;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_f_div.sv
// Scoreboard bench for f_div: directed cases plus random operands against an
// arithmetic reference model; a monitor checks value and latency of each done pulse.
module tb_f_div;

  localparam int LAT = 29;

  logic        clk = 1'b0;
  logic        rst, running, run;
  logic [31:0] in0, in1, out0;
  logic        done;

  f_div dut (
    .clk(clk), .rst(rst), .running(running), .run(run),
    .in0(in0), .in1(in1), .out0(out0), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    int          due;
    int          due_abs;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   run_cyc = 0;
  int   abs_cyc = 0;

  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic             s;
    int               ea, eb, e;
    longint unsigned  fa, fb, ma, mb, num, q, mant;
    bit               za, zb, ia, ib, na, nb, guard, sticky;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);  eb = int'(b[30:23]);
    fa = longint'(a[22:0]); fb = longint'(b[22:0]);
    za = (ea == 0); zb = (eb == 0);
    ia = (ea == 255) && (fa == 0); ib = (eb == 255) && (fb == 0);
    na = (ea == 255) && (fa != 0); nb = (eb == 255) && (fb != 0);
    if (na || nb || (za && zb) || (ia && ib)) return 32'h7FC00000;
    if (ia || zb) return {s, 8'hFF, 23'd0};
    if (za || ib) return {s, 31'd0};
    ma = fa + 64'h800000;
    mb = fb + 64'h800000;
    num = ma << 25;
    q = num / mb;
    sticky = (num % mb) != 0;
    if (q >= (64'd1 << 25)) begin
      mant = (q >> 2) & 64'h7FFFFF;
      guard = q[1];
      sticky = sticky | q[0];
      e = ea - eb + 127;
    end else begin
      mant = (q >> 1) & 64'h7FFFFF;
      guard = q[0];
      e = ea - eb + 126;
    end
    if (guard && (sticky || mant[0])) mant = mant + 1;
    if (mant == 64'h800000) begin
      mant = 0;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, 8'(e), mant[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] m;
    int          sel;
    sel = int'($urandom_range(0, 19));
    m   = 23'($urandom);
    if (sel == 0) e = 8'd0;
    else if (sel == 1) begin
      e = 8'hFF;
      if ($urandom_range(0, 1) == 0) m = '0;
    end else if (sel < 12) e = 8'($urandom_range(100, 154));
    else e = 8'($urandom_range(1, 254));
    if ($urandom_range(0, 7) == 0) m = '0;
    return {1'($urandom), e, m};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Monitor: compares every done pulse against the head of the scoreboard.
  logic ren;
  exp_t e_head;
  always @(posedge clk) begin
    ren = running;
    abs_cyc++;
    if (running) run_cyc++;
    #1;
    if (ren && !rst && done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_done: out0=%h with no result outstanding", out0);
      end else begin
        e_head = sb.pop_front();
        check("result", out0, e_head.val);
        check("latency", 32'(run_cyc), 32'(e_head.due));
        if (e_head.due_abs >= 0) check("abs_latency", 32'(abs_cyc), 32'(e_head.due_abs));
      end
    end
  end

  // Called at a negedge; raises run for one edge and records the expected result.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv,
                       input int abs_lat = -1);
    exp_t x;
    run = 1'b1;
    in0 = a;
    in1 = b;
    x.val     = expv;
    x.due     = run_cyc + 1 + LAT;
    x.due_abs = (abs_lat < 0) ? -1 : abs_cyc + 1 + abs_lat;
    sb.push_back(x);
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  logic [31:0] da [15] = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h3F800000,
                           32'hBF800000, 32'h00000000, 32'h7F800000, 32'h00000000,
                           32'h3F800000, 32'h7F7FFFFF, 32'h00800000, 32'h00400000,
                           32'h7FC12345, 32'hFF800000, 32'h40490FDB};
  logic [31:0] db [15] = '{32'h40000000, 32'h40400000, 32'h40400000, 32'h00000000,
                           32'h00000000, 32'h00000000, 32'h7F800000, 32'h40000000,
                           32'hFF800000, 32'h3F000000, 32'h40000000, 32'h3F800000,
                           32'h3F800000, 32'h40000000, 32'h80000000};
  logic [31:0] dq [15] = '{32'h40400000, 32'h3EAAAAAB, 32'hBEAAAAAB, 32'h7F800000,
                           32'hFF800000, 32'h7FC00000, 32'h7FC00000, 32'h00000000,
                           32'h80000000, 32'h7F800000, 32'h00000000, 32'h00000000,
                           32'h7FC00000, 32'hFF800000, 32'hFF800000};

  initial begin
    rst = 1'b1; running = 1'b1; run = 1'b0; in0 = '0; in1 = '0;
    repeat (3) @(negedge clk);
    check("reset_out0", out0, 32'h0);
    check("reset_done", 32'(done), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      issue(da[i], db[i], dq[i]);
      drain();
    end

    // A run pulse while busy must be ignored.
    issue(32'h40C00000, 32'h40000000, 32'h40400000);
    repeat (10) @(negedge clk);
    run = 1'b1; in0 = 32'h3F800000; in1 = 32'h40400000;
    @(negedge clk);
    run = 1'b0;
    drain();
    repeat (40) @(negedge clk);

    // Back-to-back: second run lands on the done edge of the first.
    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB);
    repeat (LAT - 1) @(negedge clk);
    issue(32'h40C00000, 32'h40000000, 32'h40400000);
    drain();

    // Five paused cycles mid-division stretch the wall-clock latency to 34.
    issue(32'h40C00000, 32'h40000000, 32'h40400000, LAT + 5);
    repeat (10) @(negedge clk);
    running = 1'b0;
    repeat (5) @(negedge clk);
    running = 1'b1;
    drain();

    // Reset mid-division aborts with no done pulse.
    issue(32'h40C00000, 32'h40000000, 32'h40400000);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("abort_out0", out0, 32'h0);
    check("abort_done", 32'(done), 32'h0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(32'h40C00000, 32'h40000000, 32'h40400000);
    drain();

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b;
      a = rand_fp();
      b = rand_fp();
      issue(a, b, ref_div(a, b));
      if ($urandom_range(0, 3) == 0) begin
        repeat (LAT - 1) @(negedge clk);
        a = rand_fp();
        b = rand_fp();
        issue(a, b, ref_div(a, b));
      end
      drain();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
